data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 40 ++++
 rtl/data_memory.sv | 53 +++++
 tb/tb_data_memory.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data memory: default geometry and the
// byte-address to word-index mapping.
package dmem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 64;

  // Word index is the byte address with the two byte-offset bits dropped,
  // kept to aw bits; the caller narrows the result to its own index width.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Register-array storage: asynchronous reset loads word i with the value i,
// one synchronous write port, one combinational read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[idx] = wdata;
    end
  end

  // Reset dominates, so writes presented while reset is high never land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory with byte-address decode and out-of-range masking.
// Optional alignment checking is compiled in with DMEM_ALIGN_CHECK_EN.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     word_idx;
  logic              in_range;
  logic              access_ok;
  logic [DATA_W-1:0] array_rdata;

  assign word_idx = AW'(word_index(address, AW));
  // Any set bit above the word-index field addresses past the last word.
  assign in_range = ((address >> (AW + 2)) == 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (address[1:0] != 2'b00);
  assign access_ok  = in_range & ~misaligned;
`else
  assign access_ok  = in_range;
`endif

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (write & access_ok),
    .idx  (word_idx),
    .wdata(write_data),
    .rdata(array_rdata)
  );

  assign read_data = access_ok ? array_rdata : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed reset/write/boundary cases,
// then randomized traffic checked every cycle against an array model.
module tb_data_memory;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int W      = DATA_W;

  logic              clk;
  logic              reset;
  logic              write;
  logic [31:0]       address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              misaligned;
`endif

  data_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misaligned(misaligned)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0] model [DEPTH];
  logic [W-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  function automatic bit addr_usable(input logic [31:0] a);
    bit ok;
    ok = (a < 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % 4) != 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [W-1:0] exp_read(input logic [31:0] a);
    if (!addr_usable(a)) return '0;
    return model[(a / 4) % DEPTH];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = W'(i);
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else if (write && addr_usable(address)) model[(address / 4) % DEPTH] = write_data;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (addr 0x%08h)", name, act, exp, address);
  endtask

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_read", read_data, exp_read(address));
`ifdef DMEM_ALIGN_CHECK_EN
      check("cycle_misaligned", W'(misaligned), W'(address[1:0] != 2'b00));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic set_in(input logic wr, input logic [31:0] a, input logic [W-1:0] d);
    write = wr;
    address = a;
    write_data = d;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_in(1'b0, 32'd0, '0);
    assert_reset();

    // Reset pattern visible with no clock edge.
    #1 address = 32'd12;
    #1 check("reset_addr12", read_data, 32'd3);
    address = 32'd20;
    #1 check("reset_addr20", read_data, 32'd5);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Overwrite word 5 with zero.
    set_in(1'b1, 32'd20, 32'd0);
    edge_step();
    write = 1'b0;
    #1 check("wr20_zero", read_data, 32'd0);
    address = 32'd12;
    #1 check("addr12_still3", read_data, 32'd3);

    // No bypass: old value before the edge, new value after.
    set_in(1'b1, 32'd0, 32'hDEAD_BEEF);
    #1 check("wr0_before_edge", read_data, 32'd0);
    edge_step();
    check("wr0_after_edge", read_data, 32'hDEAD_BEEF);
    write = 1'b0;
    #1 assert_reset();
    #1 check("reset_midcycle_addr0", read_data, 32'd0);
    address = 32'd20;
    #1 check("reset_restores20", read_data, 32'd5);
    reset = 1'b0;

    // Out-of-range write is dropped and reads back zero.
    set_in(1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF);
    #1 check("oor_read", read_data, 32'd0);
    edge_step();
    write = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(W'(i));
    for (int i = 0; i < DEPTH; i++) begin
      address = 32'(4 * i);
      #1 check($sformatf("sweep_word%0d", i), read_data, exp_q.pop_front());
    end
    edge_step();

    // Byte offset inside word 3.
    set_in(1'b1, 32'd13, 32'd7);
`ifdef DMEM_ALIGN_CHECK_EN
    #1 check("mis_flag", W'(misaligned), 32'd1);
    check("mis_read", read_data, 32'd0);
    edge_step();
    write = 1'b0;
    address = 32'd12;
    #1 check("mis_word3_kept", read_data, 32'd3);
`else
    #1 check("offset_read_before", read_data, 32'd3);
    edge_step();
    write = 1'b0;
    address = 32'd12;
    #1 check("offset_word3_written", read_data, 32'd7);
`endif

    // Writes held off while reset is high across edges.
    edge_step();
    assert_reset();
    set_in(1'b1, 32'd8, 32'd99);
    edge_step();
    edge_step();
    write = 1'b0;
    reset = 1'b0;
    #1 check("write_during_reset", read_data, 32'd2);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      edge_step();
      case ($urandom_range(0, 9))
        0:       address = $urandom();
        1:       address = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        2, 3:    address = 32'($urandom_range(0, 4 * DEPTH - 1));
        default: address = 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      write = ($urandom_range(0, 1) == 1);
      write_data = $urandom();
      if ($urandom_range(0, 39) == 0) begin
        #1 assert_reset();
        #1 reset = 1'b0;
      end
    end

    edge_step();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
